// File: rtl/panda_divider.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU): restoring division, one quotient bit
// per cycle, valid/ready handshake on both sides.
module panda_divider #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = (Width > 2) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             rem_sel_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [Width-1:0] dvd_q;
  logic [Width-1:0] div_q;
  logic [Width-1:0] rem_q;
  logic [Width-1:0] result_q;

  // Accept-side decode
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [Width-1:0] a_mag;
  logic [Width-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic [Width-1:0] special_res;

  always_comb begin
    is_signed   = ~op_i[0];
    a_neg       = is_signed & operand_a_i[Width-1];
    b_neg       = is_signed & operand_b_i[Width-1];
    a_mag       = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
    b_mag       = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    div_zero    = (operand_b_i == '0);
    sgn_ovf     = is_signed & (operand_a_i == {1'b1, {(Width-1){1'b0}}}) & (operand_b_i == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? operand_a_i : '1;
    end else if (sgn_ovf) begin
      special_res = op_i[1] ? '0 : operand_a_i;
    end
  end

  // One restoring step; the shifted remainder keeps its carry-out bit so large
  // unsigned divisors still compare correctly.
  logic [Width:0]   rem_sh;
  logic [Width:0]   trial;
  logic             q_bit;
  logic [Width-1:0] rem_nxt;
  logic [Width-1:0] dvd_nxt;
  logic [Width-1:0] quo_fix;
  logic [Width-1:0] rem_fix;
  logic [Width-1:0] final_res;

  always_comb begin
    rem_sh    = {rem_q, dvd_q[Width-1]};
    trial     = rem_sh - {1'b0, div_q};
    q_bit     = ~trial[Width];
    rem_nxt   = q_bit ? trial[Width-1:0] : rem_sh[Width-1:0];
    dvd_nxt   = {dvd_q[Width-2:0], q_bit};
    quo_fix   = neg_quo_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
    rem_fix   = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
    final_res = rem_sel_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            rem_sel_q <= op_i[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvd_q     <= a_mag;
            div_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (div_zero || sgn_ovf) begin
              result_q <= special_res;
              state_q  <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            result_q <= final_res;
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign valid_o  = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_panda_divider.sv
// Self-checking bench for panda_divider: vector table through a result scoreboard, plus
// hand-written hold, flush and mid-operation reset sequences.
module tb_panda_divider;

  localparam int unsigned Width = 32;

  logic             clk;
  logic             rst_ni;
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [Width-1:0] operand_a_i;
  logic [Width-1:0] operand_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] result_o;

  panda_divider #(.Width(Width)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;
  localparam int Full = Width + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold,
                       input string name);
    int          cyc;
    logic [31:0] e;
    @(negedge clk);
    chk({name, " ready_before"}, {31'b0, ready_o}, 32'd1);
    ready_i     = (hold == 0);
    valid_i     = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    valid_i     = 1'b0;
    op_i        = 2'($urandom);
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(lat));
    e = sb.pop_front();
    chk({name, " result"}, result_o, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      chk({name, " hold_valid"}, {31'b0, valid_o}, 32'd1);
      chk({name, " hold_result"}, result_o, e);
      chk({name, " hold_ready"}, {31'b0, ready_o}, 32'd0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " back_idle"}, {30'b0, ready_o, valid_o}, 32'd2);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vhi;

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b1;
    op_i        = '0;
    operand_a_i = '0;
    operand_b_i = '0;

    vecs.push_back('{OpDivu, 32'd100, 32'd7, 32'd14, Full, "divu_100_7"});
    vecs.push_back('{OpRemu, 32'd100, 32'd7, 32'd2, Full, "remu_100_7"});
    vecs.push_back('{OpDiv, -32'sd7, 32'd2, 32'hFFFF_FFFD, Full, "div_m7_2"});
    vecs.push_back('{OpRem, -32'sd7, 32'd2, 32'hFFFF_FFFF, Full, "rem_m7_2"});
    vecs.push_back('{OpDiv, 32'd7, -32'sd2, 32'hFFFF_FFFD, Full, "div_7_m2"});
    vecs.push_back('{OpRem, 32'd7, -32'sd2, 32'd1, Full, "rem_7_m2"});
    vecs.push_back('{OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0"});
    vecs.push_back('{OpRem, 32'd5, 32'd0, 32'd5, 1, "rem_5_0"});
    vecs.push_back('{OpDiv, -32'sd5, 32'd0, 32'hFFFF_FFFF, 1, "div_m5_0"});
    vecs.push_back('{OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
    vecs.push_back('{OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf"});
    vecs.push_back('{OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, Full, "divu_min_max"});
    vecs.push_back('{OpDivu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, Full, "divu_max_max"});
    vecs.push_back('{OpRemu, 32'hFFFF_FFFF, 32'd3, 32'd0, Full, "remu_max_3"});
    vecs.push_back('{OpDiv, 32'h8000_0000, 32'd3, 32'hD555_5556, Full, "div_min_3"});
    vecs.push_back('{OpRem, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, Full, "rem_min_3"});
    vecs.push_back('{OpRemu, 32'd7, 32'd100, 32'd7, Full, "remu_7_100"});
    vecs.push_back('{OpDivu, 32'd0, 32'd5, 32'd0, Full, "divu_0_5"});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, ready_o}, 32'd1);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, vecs[i].name);
    end

    // Consumer stalls for 5 cycles in DONE.
    do_op(OpDivu, 32'd1000, 32'd10, 32'd100, Full, 5, "hold_divu");

    // Flush in IDLE must block the accept.
    @(negedge clk);
    valid_i     = 1'b1;
    flush_i     = 1'b1;
    op_i        = OpDivu;
    operand_a_i = 32'd9;
    operand_b_i = 32'd3;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_idle_blocks", {31'b0, ready_o}, 32'd1);

    // Flush at CALC step 10.
    @(negedge clk);
    valid_i     = 1'b1;
    op_i        = OpDivu;
    operand_a_i = 32'd12345;
    operand_b_i = 32'd11;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("flush_calc_started", {31'b0, ready_o}, 32'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_calc_idle", {30'b0, ready_o, valid_o}, 32'd2);
    vhi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) vhi++;
    end
    chk("flush_no_valid", 32'(vhi), 32'd0);
    do_op(OpDivu, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, Full, 0, "after_flush");

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    valid_i     = 1'b1;
    op_i        = OpDiv;
    operand_a_i = 32'd77;
    operand_b_i = 32'd5;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    do_op(OpDivu, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, Full, 0, "after_reset");

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
